// File: rtl/vga_sync_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared VGA timing defaults (640x480@60), coordinate width,
//               reset colour and small helper types for the sync generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

   // Coordinate width; both raster totals must fit in this many bits (<=1024)
   localparam int COORD_W = 10;

   // Default horizontal timing, in pixels
   localparam int H_DISP  = 640;
   localparam int H_FP    = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BP    = 48;

   // Default vertical timing, in lines
   localparam int V_DISP  = 480;
   localparam int V_FP    = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BP    = 33;

   // Derived raster totals for the defaults (800 x 525)
   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [2:0]         rgb_t;

   // Colour shown until the first frame boundary after reset: white
   localparam rgb_t RST_COLOR = 3'b111;

   // True when pos lies inside the closed window [first, last]
   function automatic logic in_window(input coord_t pos,
                                      input coord_t first,
                                      input coord_t last);
      return (pos >= first) && (pos <= last);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Raster bundle between the VGA sync generator (master) and the
//               downstream text/font pixel generator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   rgb_t   color_sw;      // raw, asynchronous colour switches {R,G,B}
   logic   hsync;
   logic   vsync;
   logic   video_on;
   logic   p_tick;
   coord_t pixel_x;
   coord_t pixel_y;
   logic   frame_start;
   rgb_t   color_rgb;     // frame-stable colour

   // Timing generator side
   modport master (
      input  color_sw,
      output hsync, vsync, video_on, p_tick,
      output pixel_x, pixel_y, frame_start, color_rgb
   );

   // Pixel generator side
   modport slave (
      output color_sw,
      input  hsync, vsync, video_on, p_tick,
      input  pixel_x, pixel_y, frame_start, color_rgb
   );

endinterface
`default_nettype wire

// File: rtl/vga_sync_gen_pix_tick.sv
`default_nettype none
// ============================================================================
// Module      : pix_tick_gen
// Description : Mod-PIX_DIV free-running divider. Emits a one-clock pixel
//               tick on the last count of every PIX_DIV-clock period.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_tick_gen #(
   parameter int PIX_DIV = 2          // clocks per pixel, must be >= 2
) (
   input  logic clk,
   input  logic rst,
   output logic o_p_tick
);

   localparam int                 c_cnt_w = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(PIX_DIV - 1);

   logic [c_cnt_w-1:0] r_div_cnt;

   // Divider count 0..PIX_DIV-1, wrapping; restarts at 0 on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (r_div_cnt == c_last) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + 1'b1;
      end
   end

   // Tick decoded straight from the register, so it is low during reset
   assign o_p_tick = (r_div_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing generator. Pixel-rate tick from the system
//               clock, h/v counters, registered syncs aligned with the
//               counters, visible-area flag, frame strobe and a colour latch
//               that only changes on frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int PIX_DIV  = 2,        // system clocks per pixel (>= 2)
   parameter int HD       = H_DISP,
   parameter int HF       = H_FP,
   parameter int HS       = H_SYNC,
   parameter int HB       = H_BP,
   parameter int VD       = V_DISP,
   parameter int VF       = V_FP,
   parameter int VS       = V_SYNC,
   parameter int VB       = V_BP,
   parameter bit SYNC_POL = 1'b0      // active level of both sync pulses
) (
   input  logic           clk,
   input  logic           reset,
   vga_sync_gen_if.master vga
);

   // Raster geometry; both totals are expected to fit in COORD_W bits
   localparam int     c_h_total  = HD + HF + HS + HB;
   localparam int     c_v_total  = VD + VF + VS + VB;
   localparam coord_t c_h_last   = coord_t'(c_h_total - 1);
   localparam coord_t c_v_last   = coord_t'(c_v_total - 1);
   localparam coord_t c_h_disp   = coord_t'(HD);
   localparam coord_t c_v_disp   = coord_t'(VD);
   localparam coord_t c_hs_first = coord_t'(HD + HF);
   localparam coord_t c_hs_last  = coord_t'(HD + HF + HS - 1);
   localparam coord_t c_vs_first = coord_t'(VD + VF);
   localparam coord_t c_vs_last  = coord_t'(VD + VF + VS - 1);

   logic   w_p_tick;
   logic   w_h_last;
   logic   w_v_last;
   logic   w_frame_start;
   coord_t w_h_next;
   coord_t w_v_next;
   logic   w_hs_act;
   logic   w_vs_act;

   coord_t r_h_cnt;
   coord_t r_v_cnt;
   logic   r_hsync;
   logic   r_vsync;
   rgb_t   r_sw_meta;
   rgb_t   r_sw_sync;
   rgb_t   r_color_rgb;

   pix_tick_gen #(
      .PIX_DIV (PIX_DIV)
   ) u_pix_tick (
      .clk      (clk),
      .rst      (reset),
      .o_p_tick (w_p_tick)
   );

   // Next-state raster position; holds between ticks, wraps at line/frame end
   always_comb begin
      w_h_last = (r_h_cnt == c_h_last);
      w_v_last = (r_v_cnt == c_v_last);
      w_h_next = r_h_cnt;
      w_v_next = r_v_cnt;
      if (w_p_tick) begin
         if (w_h_last) begin
            w_h_next = '0;
            w_v_next = w_v_last ? '0 : r_v_cnt + 1'b1;
         end else begin
            w_h_next = r_h_cnt + 1'b1;
         end
      end
   end

   // Sync windows are judged on the next position so that the registered
   // syncs line up with the counters they are registered alongside
   assign w_hs_act      = in_window(w_h_next, c_hs_first, c_hs_last);
   assign w_vs_act      = in_window(w_v_next, c_vs_first, c_vs_last);
   assign w_frame_start = w_p_tick && w_h_last && w_v_last;

   // Raster counters and registered sync outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
         r_hsync <= ~SYNC_POL;
         r_vsync <= ~SYNC_POL;
      end else begin
         r_h_cnt <= w_h_next;
         r_v_cnt <= w_v_next;
         r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
         r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      end
   end

   // Two-flop synchronizer for the asynchronous colour switches
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= vga.color_sw;
         r_sw_sync <= r_sw_meta;
      end
   end

   // Colour only changes on the edge that wraps to (0,0), so a frame never tears
   always_ff @(posedge clk) begin
      if (reset) begin
         r_color_rgb <= RST_COLOR;
      end else if (w_frame_start) begin
         r_color_rgb <= r_sw_sync;
      end
   end

   assign vga.p_tick      = w_p_tick;
   assign vga.pixel_x     = r_h_cnt;
   assign vga.pixel_y     = r_v_cnt;
   assign vga.hsync       = r_hsync;
   assign vga.vsync       = r_vsync;
   assign vga.video_on    = (r_h_cnt < c_h_disp) && (r_v_cnt < c_v_disp);
   assign vga.frame_start = w_frame_start;
   assign vga.color_rgb   = r_color_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen on a shrunken raster
//               (30 x 20) so whole frames are short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;
   import vga_timing_pkg::*;

   localparam int D   = 2;
   localparam int HD  = 16, HF = 4, HS = 6, HB = 4;
   localparam int VD  = 12, VF = 2, VS = 2, VB = 4;
   localparam int HT  = HD + HF + HS + HB;   // 30
   localparam int VT  = VD + VF + VS + VB;   // 20
   localparam int FT  = HT * VT;             // pixels per frame
   localparam int FCLK = D * FT;             // clocks per frame
   localparam bit POL = 1'b0;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model state: clocks elapsed since reset released, latched colour
   int   k = 0;
   rgb_t exp_color = RST_COLOR;

   vga_sync_gen_if vga();

   vga_sync_gen #(
      .PIX_DIV (D),
      .HD (HD), .HF (HF), .HS (HS), .HB (HB),
      .VD (VD), .VF (VF), .VS (VS), .VB (VB),
      .SYNC_POL (POL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .vga   (vga)
   );

   always #5 clk = ~clk;

   // Model: position is a pure function of elapsed clocks; colour is captured
   // from the switches on the edge that ends the last pixel of a frame
   always @(posedge clk) begin
      if (reset) begin
         k = 0;
         exp_color = RST_COLOR;
      end else begin
         if ((k % D) == D - 1 && ((k / D) % FT) == FT - 1)
            exp_color = vga.color_sw;
         k = k + 1;
      end
   end

   function automatic int   m_x();    return (k / D) % HT;        endfunction
   function automatic int   m_y();    return ((k / D) / HT) % VT; endfunction
   function automatic logic m_tick(); return (k % D) == D - 1;    endfunction
   function automatic logic m_hs();
      int x = m_x();
      return (x >= HD + HF && x < HD + HF + HS) ? POL : ~POL;
   endfunction
   function automatic logic m_vs();
      int y = m_y();
      return (y >= VD + VF && y < VD + VF + VS) ? POL : ~POL;
   endfunction
   function automatic logic m_von(); return (m_x() < HD) && (m_y() < VD); endfunction
   function automatic logic m_fs();
      return m_tick() && m_x() == HT - 1 && m_y() == VT - 1;
   endfunction

   // Advance to the first clock at which the DUT shows (x,y); bounded
   task automatic wait_xy(input int x, input int y, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < FCLK + 4 * D; i++) begin
         @(negedge clk);
         if (vga.pixel_x == 10'(x) && vga.pixel_y == 10'(y)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vga.color_sw = 3'b111;
      repeat (3) @(negedge clk);
      n_tests++;
      if (vga.pixel_x !== 10'd0 || vga.pixel_y !== 10'd0) begin
         n_fail++; $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", vga.pixel_x, vga.pixel_y);
      end
      n_tests++;
      if (vga.hsync !== 1'b1 || vga.vsync !== 1'b1) begin
         n_fail++; $display("FAIL reset_sync: got hs=%b vs=%b want 1,1", vga.hsync, vga.vsync);
      end
      n_tests++;
      if (vga.color_rgb !== 3'b111) begin
         n_fail++; $display("FAIL reset_color: got %b want 111", vga.color_rgb);
      end
      n_tests++;
      if (vga.p_tick !== 1'b0 || vga.frame_start !== 1'b0 || vga.video_on !== 1'b1) begin
         n_fail++; $display("FAIL reset_flags: got tick=%b fs=%b von=%b want 0,0,1",
                            vga.p_tick, vga.frame_start, vga.video_on);
      end
      reset = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_tests++;
         if (vga.p_tick !== ((i % D) == D - 1) || vga.pixel_x !== 10'(i / D)) begin
            n_fail++; $display("FAIL startup clk%0d: got tick=%b x=%0d want tick=%b x=%0d",
                               i, vga.p_tick, vga.pixel_x, (i % D) == D - 1, i / D);
         end
      end
   endtask

   task automatic test_line();
      int hs_clks = 0;
      for (int i = 0; i < D * HT; i++) begin
         @(negedge clk);
         if (vga.hsync === POL) hs_clks++;
         n_tests++;
         if (vga.pixel_x !== 10'(m_x()) || vga.pixel_y !== 10'(m_y()) || vga.hsync !== m_hs()) begin
            n_fail++; $display("FAIL line: got x=%0d y=%0d hs=%b want x=%0d y=%0d hs=%b",
                               vga.pixel_x, vga.pixel_y, vga.hsync, m_x(), m_y(), m_hs());
         end
      end
      n_tests++;
      if (hs_clks != HS * D) begin
         n_fail++; $display("FAIL hsync_width: got %0d clks want %0d", hs_clks, HS * D);
      end
   endtask

   task automatic test_frame();
      int fs_cnt = 0;
      int vs_clks = 0;
      for (int i = 0; i < FCLK; i++) begin
         @(negedge clk);
         if (vga.frame_start === 1'b1) fs_cnt++;
         if (vga.vsync === POL) vs_clks++;
         n_tests++;
         if (vga.pixel_y !== 10'(m_y()) || vga.vsync !== m_vs() ||
             vga.video_on !== m_von() || vga.frame_start !== m_fs()) begin
            n_fail++; $display("FAIL frame: got y=%0d vs=%b von=%b fs=%b want y=%0d vs=%b von=%b fs=%b",
                               vga.pixel_y, vga.vsync, vga.video_on, vga.frame_start,
                               m_y(), m_vs(), m_von(), m_fs());
         end
      end
      n_tests++;
      if (fs_cnt != 1) begin
         n_fail++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt);
      end
      n_tests++;
      if (vs_clks != VS * HT * D) begin
         n_fail++; $display("FAIL vsync_width: got %0d clks want %0d", vs_clks, VS * HT * D);
      end
   endtask

   task automatic test_video_on();
      int px [5] = '{0, HD, HD - 1, 0,  HT - 1};
      int py [5] = '{0, 0,  VD - 1, VD, VT - 1};
      logic ev [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      bit ok;
      for (int i = 0; i < 5; i++) begin
         wait_xy(px[i], py[i], ok);
         n_tests++;
         if (!ok) begin
            n_fail++; $display("FAIL video_on_reach(%0d,%0d): position not seen, last (%0d,%0d)",
                               px[i], py[i], vga.pixel_x, vga.pixel_y);
         end else if (vga.video_on !== ev[i]) begin
            n_fail++; $display("FAIL video_on(%0d,%0d): got %b want %b",
                               px[i], py[i], vga.video_on, ev[i]);
         end
      end
   endtask

   task automatic test_color();
      rgb_t new_c = 3'($urandom_range(0, 6));
      bit   ok;
      bit   wrapped = 1'b0;
      int   bad = 0;
      wait_xy(HD / 2, VD / 2, ok);
      n_tests++;
      if (!ok) begin
         n_fail++; $display("FAIL color_reach: mid-frame position not seen");
      end
      vga.color_sw = new_c;
      for (int i = 0; i < FCLK + 4; i++) begin
         @(negedge clk);
         if (k % FCLK == 0) begin
            wrapped = 1'b1;
            break;
         end
         if (vga.color_rgb !== 3'b111) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL color_held: %0d clks changed early, want 0", bad);
      end
      n_tests++;
      if (!wrapped || vga.color_rgb !== new_c || vga.pixel_x !== 10'd0 || vga.pixel_y !== 10'd0 ||
          vga.hsync !== ~POL || vga.vsync !== ~POL) begin
         n_fail++; $display("FAIL color_wrap: got c=%b (%0d,%0d) hs=%b vs=%b want c=%b (0,0) inactive syncs",
                            vga.color_rgb, vga.pixel_x, vga.pixel_y, vga.hsync, vga.vsync, new_c);
      end
      bad = 0;
      for (int i = 0; i < FCLK + D; i++) begin
         @(negedge clk);
         if (vga.color_rgb !== new_c) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++; $display("FAIL color_next_frame: %0d clks differ from %b", bad, new_c);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int pass = 0; pass < 2; pass++) begin
         // pass 0: visible area, syncs high; pass 1: inside both sync pulses
         if (pass == 0) wait_xy(HD / 2, VD / 2, ok);
         else           wait_xy(HD + HF + 1, VD + VF, ok);
         n_tests++;
         if (!ok) begin
            n_fail++; $display("FAIL reset_mid_reach pass%0d: position not seen", pass);
         end else if (vga.hsync !== (pass == 0 ? ~POL : POL) || vga.vsync !== (pass == 0 ? ~POL : POL)) begin
            n_fail++; $display("FAIL reset_mid_pre pass%0d: got hs=%b vs=%b", pass, vga.hsync, vga.vsync);
         end
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         n_tests++;
         if (vga.pixel_x !== 10'd0 || vga.pixel_y !== 10'd0 || vga.hsync !== 1'b1 ||
             vga.vsync !== 1'b1 || vga.color_rgb !== 3'b111 || vga.p_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid pass%0d: got (%0d,%0d) hs=%b vs=%b c=%b tick=%b want (0,0) 1 1 111 0",
                               pass, vga.pixel_x, vga.pixel_y, vga.hsync, vga.vsync, vga.color_rgb, vga.p_tick);
         end
         for (int i = 1; i <= 3 * D; i++) begin
            @(negedge clk);
            n_tests++;
            if (vga.pixel_x !== 10'(i / D) || vga.pixel_y !== 10'd0) begin
               n_fail++; $display("FAIL reset_resume pass%0d clk%0d: got x=%0d want %0d",
                                  pass, i, vga.pixel_x, i / D);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [27:0] got, exp;
      for (int i = 0; i < 4 * FCLK; i++) begin
         @(negedge clk);
         got = {vga.pixel_x, vga.pixel_y, vga.hsync, vga.vsync, vga.video_on,
                vga.p_tick, vga.frame_start, vga.color_rgb};
         exp = {10'(m_x()), 10'(m_y()), m_hs(), m_vs(), m_von(), m_tick(), m_fs(), exp_color};
         n_tests++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random clk%0d: got %h want %h (x,y,hs,vs,von,tick,fs,rgb)", i, got, exp);
         end
         reset = ($urandom_range(0, 699) == 0);
         // Switches move only when the next frame boundary is comfortably away
         if ($urandom_range(0, 59) == 0 && (FCLK - (k % FCLK)) > 4)
            vga.color_sw = 3'($urandom_range(0, 7));
      end
      reset = 1'b0;
   endtask

   initial begin
      vga.color_sw = 3'b111;
      test_reset();
      test_line();
      test_frame();
      test_video_on();
      test_color();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
